// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: issues one ADC conversion command per sample period and turns the response into
// a signed audio sample strobe. Define ADC_SEQ_TIMEOUT_EN to build the response watchdog.
module adc_sample_sequencer #(
  parameter int unsigned SAMPLE_DIV     = 1042,
  parameter int unsigned CHANNEL        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  output logic        cmd_valid,
  output logic [4:0]  cmd_channel,
  output logic        cmd_sop,
  output logic        cmd_eop,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic [4:0]  rsp_channel,
  input  logic [11:0] rsp_data,
  input  logic        rsp_sop,
  input  logic        rsp_eop,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic        overrun,
  output logic        chan_err,
  output logic        timeout_err
);

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [4:0]  CHAN     = 5'(CHANNEL);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  typedef struct packed {
    logic        vld;
    logic [4:0]  ch;
    logic [11:0] data;
  } rsp_t;

  rsp_t        rsp;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tick, rsp_hit, wd_expire;
  logic        cmd_valid_q, cmd_valid_d;
  logic        sample_valid_q, sample_valid_d;
  logic [11:0] sample_data_q, sample_data_d;
  logic        overrun_q, overrun_d;
  logic        chan_err_q, chan_err_d;

  assign rsp     = '{vld: rsp_valid, ch: rsp_channel, data: rsp_data};
  assign rsp_hit = rsp.vld && (rsp.ch == CHAN);

  // Single-beat packets: framing bits carry no information.
  logic unused_rsp_frame;
  assign unused_rsp_frame = rsp_sop ^ rsp_eop;

  assign tick = enable && (cnt_q == DIV_LAST);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!enable || tick) cnt_d = '0;
  end

  always_comb begin
    state_d        = state_q;
    sample_valid_d = 1'b0;
    sample_data_d  = sample_data_q;
    overrun_d      = tick && (state_q != IDLE);
    chan_err_d     = 1'b0;
    case (state_q)
      IDLE:     if (tick) state_d = ISSUE;
      ISSUE:    if (cmd_ready) state_d = WAIT_RSP;
      WAIT_RSP: begin
        if (rsp_hit) begin
          state_d        = IDLE;
          sample_valid_d = 1'b1;
          // offset-binary to two's complement: flip the MSB
          sample_data_d  = {~rsp.data[11], rsp.data[10:0]};
        end else begin
          chan_err_d = rsp.vld;
          if (wd_expire) state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
    cmd_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cmd_valid_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_data_q  <= '0;
      overrun_q      <= 1'b0;
      chan_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cmd_valid_q    <= cmd_valid_d;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
      overrun_q      <= overrun_d;
      chan_err_q     <= chan_err_d;
    end
  end

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  // Held at zero outside WAIT_RSP, so it starts from zero on every entry.
  assign wd_expire = (state_q == WAIT_RSP) && (wd_q == WD_LAST);
  assign wd_d      = (state_q == WAIT_RSP) ? wd_q + 16'd1 : 16'd0;
  assign timeout_d = wd_expire && !rsp_hit;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign cmd_valid    = cmd_valid_q;
  assign cmd_sop      = cmd_valid_q;
  assign cmd_eop      = cmd_valid_q;
  assign cmd_channel  = CHAN;
  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
  assign overrun      = overrun_q;
  assign chan_err     = chan_err_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: ADC responder plus a transaction-level reference model checked every cycle,
// followed by directed event counts for each scenario.
module tb_adc_sample_sequencer;
  localparam int DIV = 8;
  localparam int CH  = 1;
  localparam int TO  = 10;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n, enable, cmd_ready, rsp_valid, rsp_sop, rsp_eop;
  logic [4:0]  rsp_channel, cmd_channel;
  logic [11:0] rsp_data, sample_data;
  logic        cmd_valid, cmd_sop, cmd_eop, sample_valid, overrun, chan_err, timeout_err;

  adc_sample_sequencer #(.SAMPLE_DIV(DIV), .CHANNEL(CH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .rsp_sop(rsp_sop), .rsp_eop(rsp_eop), .sample_valid(sample_valid), .sample_data(sample_data),
    .overrun(overrun), .chan_err(chan_err), .timeout_err(timeout_err));

  always #5 clk_clk = ~clk_clk;

  int total = 0;
  int bad   = 0;

  // reference model: busy = transaction outstanding, acc = command already accepted
  int          m_phase, m_wait;
  bit          m_busy, m_acc;
  bit          e_cv, e_sv, e_ovr, e_cerr, e_to;
  logic [11:0] e_sd;

  // ADC responder / stimulus controls
  int  cyc = 0, en_edges = 0, lat = 3, stall_cfg = 0, stall_left = 0;
  int  rsp_edge, wrong_edge, acc_edge, acc_en, to_gap;
  bit  pending, inject, inj_cur, drop, spur, rnd, hold_low, prev_cv;
  int  n_acc, n_ovr, n_cerr, n_to;
  int          rise_q[$];
  logic [11:0] samp_q[$];
  logic [11:0] dq[$];
  logic [11:0] conv_exp [4] = '{12'h000, 12'h7FF, 12'h800, 12'hFFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_wait = 0; m_busy = 0; m_acc = 0;
    e_cv = 0; e_sv = 0; e_ovr = 0; e_cerr = 0; e_to = 0; e_sd = '0;
  endtask

  task automatic m_step(input bit en, input bit rdy, input bit rv, input logic [4:0] rch,
                        input logic [11:0] rd);
    bit tk;
    tk      = en && (m_phase == DIV - 1);
    m_phase = (en && !tk) ? m_phase + 1 : 0;
    e_ovr   = tk && m_busy;
    e_sv = 0; e_cerr = 0; e_to = 0;
    if (!m_busy) begin
      m_busy = tk; m_acc = 0;
    end else if (!m_acc) begin
      if (rdy) begin m_acc = 1; m_wait = 0; end
    end else if (rv && rch == 5'(CH)) begin
      e_sv = 1; e_sd = 12'(int'(rd) - 2048); m_busy = 0;
    end else begin
      e_cerr = rv;
`ifdef ADC_SEQ_TIMEOUT_EN
      if (m_wait == TO - 1) begin e_to = 1; m_busy = 0; end
      else m_wait++;
`endif
    end
    e_cv = m_busy && !m_acc;
  endtask

  task automatic clear_stats();
    n_acc = 0; n_ovr = 0; n_cerr = 0; n_to = 0; to_gap = -1; acc_en = -1;
    rise_q.delete(); samp_q.delete(); dq.delete();
  endtask

  // Called just after a falling edge: check, record, drive inputs for the next rising edge.
  task automatic cycle();
    chk("cmd_valid", cmd_valid, e_cv);
    chk("cmd_sop", cmd_sop, e_cv);
    chk("cmd_eop", cmd_eop, e_cv);
    chk("cmd_channel", cmd_channel, CH);
    chk("sample_valid", sample_valid, e_sv);
    chk("sample_data", sample_data, e_sd);
    chk("overrun", overrun, e_ovr);
    chk("chan_err", chan_err, e_cerr);
    chk("timeout_err", timeout_err, e_to);

    if (cmd_valid && !prev_cv) begin
      rise_q.push_back(en_edges);
      stall_left = rnd ? int'($urandom_range(0, 2)) : stall_cfg;
    end
    if (sample_valid) samp_q.push_back(sample_data);
    if (overrun) n_ovr++;
    if (chan_err) n_cerr++;
    if (timeout_err) begin n_to++; to_gap = cyc - acc_edge; end
    prev_cv = cmd_valid;

    rsp_valid = 0; rsp_channel = 5'(CH); rsp_data = '0;
    if (pending && cyc + 1 == rsp_edge) begin
      pending = 0;
      if (!drop) begin
        rsp_valid = 1;
        rsp_data  = (dq.size() > 0) ? dq.pop_front() : 12'($urandom);
      end
    end else if (pending && inj_cur && cyc + 1 == wrong_edge) begin
      rsp_valid   = 1;
      rsp_channel = rnd ? 5'(CH + 1 + int'($urandom_range(0, 29))) : 5'(2);
      rsp_data    = 12'($urandom);
    end else if (!pending && spur && $urandom_range(0, 3) == 0) begin
      rsp_valid = 1; rsp_channel = 5'($urandom); rsp_data = 12'($urandom);
    end
    rsp_sop = rsp_valid; rsp_eop = rsp_valid;

    cmd_ready = (stall_left == 0) && !hold_low;
    if (stall_left > 0) stall_left--;
    if (cmd_valid && cmd_ready) begin
      pending  = 1; n_acc++;
      acc_edge = cyc + 1;
      acc_en   = enable ? en_edges + 1 : 0;
      if (rnd) lat = $urandom_range(1, 9);
      inj_cur    = (rnd ? ($urandom_range(0, 2) == 0) : inject) && (lat >= 2);
      rsp_edge   = cyc + 1 + lat;
      wrong_edge = cyc + 2;
    end
    if (enable) en_edges++; else en_edges = 0;

    m_step(enable, cmd_ready, rsp_valid, rsp_channel, rsp_data);
    @(posedge clk_clk);
    cyc++;
    @(negedge clk_clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_cmd_sop"}, cmd_sop, 0);
    chk({tag, "_cmd_eop"}, cmd_eop, 0);
    chk({tag, "_cmd_channel"}, cmd_channel, CH);
    chk({tag, "_sample_valid"}, sample_valid, 0);
    chk({tag, "_sample_data"}, sample_data, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_chan_err"}, chan_err, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset_reset_n = 1'b0;
    #1 check_reset_outputs(tag);
    m_reset();
    pending = 0; stall_left = 0; prev_cv = 0; en_edges = 0;
    enable = 0; rsp_valid = 0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset_reset_n = 1; enable = 0; cmd_ready = 1; rsp_valid = 0; rsp_channel = '0; rsp_data = '0;
    rsp_sop = 0; rsp_eop = 0;
    pending = 0; inject = 0; inj_cur = 0; drop = 0; spur = 0; rnd = 0; hold_low = 0; prev_cv = 0;
    m_reset();
    clear_stats();
    #1 reset_reset_n = 0;
    #2 check_reset_outputs("por");
    @(negedge clk_clk);
    reset_reset_n = 1;

    // period + conversion: ticks every 8 enabled edges, 3-cycle response
    clear_stats();
    dq.push_back(12'h800); dq.push_back(12'hFFF); dq.push_back(12'h000); dq.push_back(12'h7FF);
    lat = 3; enable = 1;
    run(38);
    enable = 0;
    run(12);
    chk("period_rises", rise_q.size(), 4);
    for (int i = 0; i < 3; i++)
      if (i < rise_q.size()) chk($sformatf("period_rise%0d", i), rise_q[i], DIV * (i + 1));
    chk("conv_count", samp_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < samp_q.size()) chk($sformatf("conv%0d", i), samp_q[i], conv_exp[i]);
    chk("period_overrun", n_ovr, 0);

    // backpressure: ready held low 5 cycles after cmd_valid rises
    clear_stats();
    stall_cfg = 5; enable = 1;
    run(15);
    enable = 0;
    run(12);
    stall_cfg = 0;
    chk("bp_transfers", n_acc, 1);
    chk("bp_accept_edge", acc_en, 14);
    chk("bp_samples", samp_q.size(), 1);

    // wrong channel then the right one
    clear_stats();
    inject = 1; dq.push_back(12'h9AB); enable = 1;
    run(14);
    enable = 0;
    run(10);
    inject = 0;
    chk("wc_chan_err", n_cerr, 1);
    chk("wc_samples", samp_q.size(), 1);
    if (samp_q.size() > 0) chk("wc_data", samp_q[0], 12'h1AB);

    // overrun: response 12 cycles after acceptance
    clear_stats();
    lat = 12; enable = 1;
    run(22);
    enable = 0;
    run(10);
    lat = 3;
    chk("ovr_count", n_ovr, 1);
    chk("ovr_samples", samp_q.size(), 1);

    // no response at all
    clear_stats();
    drop = 1; enable = 1;
    run(22);
    enable = 0;
    run(4);
    drop = 0;
    chk("nr_samples", samp_q.size(), 0);
`ifdef ADC_SEQ_TIMEOUT_EN
    chk("to_count", n_to, 1);
    chk("to_latency", to_gap, TO);
`else
    chk("to_count", n_to, 0);
`endif
    pulse_reset("rst_wait");

    // reset while a command is stalled in ISSUE
    hold_low = 1; enable = 1;
    run(10);
    chk("issue_before_rst", cmd_valid, 1);
    pulse_reset("rst_issue");
    hold_low = 0;
    spur = 1;
    run(10);

    // randomized traffic
    clear_stats();
    rnd = 1; enable = 1;
    for (int i = 0; i < 320; i++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      cycle();
    end
    enable = 0; spur = 0;
    run(20);
    rnd = 0;
    chk("rnd_activity", (samp_q.size() > 10), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
